scan_doubler: RTL and testbench



---
 rtl/scan_doubler_pkg.sv | 26 ++
 rtl/scan_doubler_dpram_line.sv | 23 ++
 rtl/scan_doubler.sv | 179 +++++++++++++++++
 tb/tb_scan_doubler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_doubler_pkg.sv
// Shared widths, defaults and the line-buffer entry layout for the scan doubler.
// The dim helper halves every colour channel for the scanline effect.
package scan_doubler_pkg;

  localparam int PIX_W       = 12;
  localparam int CH_W        = 4;
  localparam int ENTRY_W     = PIX_W + 1;
  localparam int HSW_DEF     = 28;
  localparam int CE_HALF_DEF = 4;
  localparam int AW_DEF      = 9;

  typedef struct packed {
    logic             blank;
    logic [PIX_W-1:0] rgb;
  } line_entry_t;

  function automatic logic [PIX_W-1:0] dim(input logic [PIX_W-1:0] px);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int c = 0; c < PIX_W / CH_W; c++) begin
      r[c*CH_W +: CH_W] = px[c*CH_W +: CH_W] >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_doubler_dpram_line.sv
// One line-buffer bank: simple dual-port RAM, synchronous write, registered read.
module dpram_line
  import scan_doubler_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = ENTRY_W
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/scan_doubler.sv
// Line doubler: buffers one input line per bank and replays the previous line
// twice at double pixel rate, optionally dimming the repeat for a scanline look.
module scan_doubler
  import scan_doubler_pkg::*;
#(
  parameter int CE_HALF = CE_HALF_DEF,
  parameter int HSW     = HSW_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic             MCLK,
  input  logic             RESET,
  input  logic             iCE,
  input  logic [PIX_W-1:0] iRGB,
  input  logic             iHBLK,
  input  logic             iVBLK,
  input  logic             iHSYN,
  input  logic             iVSYN,
  input  logic             iSL,
  output logic             oCE,
  output logic [PIX_W-1:0] oRGB,
  output logic             oHBLK,
  output logic             oVBLK,
  output logic             oHSYN,
  output logic             oVSYN
);

  localparam int            LW       = AW + 1;
  localparam int            CW       = $clog2(CE_HALF + 1);
  localparam logic [AW-1:0] HIN_MAX  = '1;
  localparam logic [LW-1:0] LEN_FULL = LW'(1 << AW);
  localparam logic [AW-1:0] HSW_CNT  = AW'(HSW);
  localparam logic [CW-1:0] PH_LAST  = CW'(CE_HALF - 1);

  logic          hsyn_prev, wr_bank, wr_full, synced, rd_valid;
  logic          vblk_lat, vsyn_lat;
  logic [AW-1:0] hin;
  logic [LW-1:0] line_len, len_eff;
  logic          boundary, wr_en, wr_tgt;
  logic [AW-1:0] wr_addr;

  logic [CW-1:0] ph_cnt;
  logic          ph_run;
  logic [AW-1:0] hout;
  logic          rep;

  logic          oce_d1, sel_d1, rep_d1, valid_d1;
  logic [AW-1:0] hout_d1;
  logic [ENTRY_W-1:0] rdata0, rdata1;
  line_entry_t   rd_entry;
  logic          out_blank;

  assign boundary = iCE & hsyn_prev & ~iHSYN;
  assign wr_en    = ~RESET & iCE & (boundary | ~wr_full);
  assign wr_addr  = boundary ? '0 : hin;
  assign wr_tgt   = boundary ? ~wr_bank : wr_bank;
  assign len_eff  = (line_len == '0) ? LEN_FULL : line_len;

  dpram_line #(.AW(AW), .DW(ENTRY_W)) u_bank0 (
    .clk_sys (MCLK),
    .we      (wr_en & ~wr_tgt),
    .waddr   (wr_addr),
    .wdata   ({iHBLK, iRGB}),
    .raddr   (hout),
    .rdata   (rdata0)
  );

  dpram_line #(.AW(AW), .DW(ENTRY_W)) u_bank1 (
    .clk_sys (MCLK),
    .we      (wr_en & wr_tgt),
    .waddr   (wr_addr),
    .wdata   ({iHBLK, iRGB}),
    .raddr   (hout),
    .rdata   (rdata1)
  );

  // The boundary pixel itself lands at address 0 of the new bank, so hin restarts at 1.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      hsyn_prev <= 1'b1;
      wr_bank   <= 1'b0;
      hin       <= '0;
      wr_full   <= 1'b0;
      line_len  <= LEN_FULL;
      synced    <= 1'b0;
      rd_valid  <= 1'b0;
      vblk_lat  <= 1'b1;
      vsyn_lat  <= 1'b1;
      oVBLK     <= 1'b1;
      oVSYN     <= 1'b1;
    end else if (iCE) begin
      hsyn_prev <= iHSYN;
      if (boundary) begin
        line_len <= {1'b0, hin};
        hin      <= AW'(1);
        wr_full  <= 1'b0;
        wr_bank  <= ~wr_bank;
        rd_valid <= synced;
        synced   <= 1'b1;
        vblk_lat <= iVBLK;
        vsyn_lat <= iVSYN;
        oVBLK    <= vblk_lat;
        oVSYN    <= vsyn_lat;
      end else if (!wr_full) begin
        if (hin == HIN_MAX) wr_full <= 1'b1;
        else                hin     <= hin + 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      oCE    <= 1'b0;
      ph_cnt <= '0;
      ph_run <= 1'b0;
    end else begin
      oCE <= iCE | (ph_run & (ph_cnt == PH_LAST));
      if (iCE) begin
        ph_cnt <= '0;
        ph_run <= 1'b1;
      end else if (ph_run) begin
        if (ph_cnt == PH_LAST) ph_run <= 1'b0;
        else                   ph_cnt <= ph_cnt + 1'b1;
      end
    end
  end

  // A boundary overrides any wrap that would happen on the same edge.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      hout <= '0;
      rep  <= 1'b0;
    end else if (boundary) begin
      hout <= '0;
      rep  <= 1'b0;
    end else if (oCE) begin
      if ({1'b0, hout} == len_eff - LW'(1)) begin
        hout <= '0;
        rep  <= ~rep;
      end else begin
        hout <= hout + 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      oce_d1   <= 1'b0;
      sel_d1   <= 1'b0;
      rep_d1   <= 1'b0;
      valid_d1 <= 1'b0;
      hout_d1  <= '0;
    end else begin
      oce_d1   <= oCE;
      sel_d1   <= ~wr_bank;
      rep_d1   <= rep;
      valid_d1 <= rd_valid;
      hout_d1  <= hout;
    end
  end

  assign rd_entry  = sel_d1 ? rdata1 : rdata0;
  assign out_blank = ~valid_d1 | rd_entry.blank;

  // Outputs only move on the delayed enable, so each pixel holds for its full slot.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      oRGB  <= '0;
      oHBLK <= 1'b1;
      oHSYN <= 1'b1;
    end else if (oce_d1) begin
      oHBLK <= out_blank;
      oHSYN <= ~(hout_d1 < HSW_CNT);
      if (out_blank)          oRGB <= '0;
      else if (rep_d1 && iSL) oRGB <= dim(rd_entry.rgb);
      else                    oRGB <= rd_entry.rgb;
    end
  end

endmodule

// File: tb/tb_scan_doubler.sv
// Randomized bench for scan_doubler: a line-level reference model predicts every
// oCE pulse and every doubled output pixel from the driven input stream.
module tb_scan_doubler;

  localparam int CE_HALF = 4;
  localparam int HSW     = 28;
  localparam int AW      = 9;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        iCE = 1'b0;
  logic [11:0] iRGB = '0;
  logic        iHBLK = 1'b1, iVBLK = 1'b1, iHSYN = 1'b1, iVSYN = 1'b1, iSL = 1'b0;
  logic        oCE;
  logic [11:0] oRGB;
  logic        oHBLK, oVBLK, oHSYN, oVSYN;

  int vectors = 0;
  int miscompares = 0;

  always #5 MCLK = ~MCLK;

  scan_doubler #(.CE_HALF(CE_HALF), .HSW(HSW), .AW(AW)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .iCE   (iCE),
    .iRGB  (iRGB),
    .iHBLK (iHBLK),
    .iVBLK (iVBLK),
    .iHSYN (iHSYN),
    .iVSYN (iVSYN),
    .iSL   (iSL),
    .oCE   (oCE),
    .oRGB  (oRGB),
    .oHBLK (oHBLK),
    .oVBLK (oVBLK),
    .oHSYN (oHSYN),
    .oVSYN (oVSYN)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares <= 50)
        $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whole input lines as queues, output position as a plain oCE count.
  typedef struct {
    int          due;
    logic [12:0] px;
    bit          valid;
    bit          rep;
    bit          hsyn;
  } pend_t;

  pend_t       pend_q[$];
  pend_t       p;
  logic [12:0] cur_line[$];
  logic [12:0] shown_line[$];
  int          line_len_m, k_out, last_ice, cyc, eff, idx;
  bit          shown_valid, synced_m, prev_hs, started;
  bit          lat_vblk, lat_vsyn, ov_vblk, ov_vsyn, exp_oce, blank;
  logic [11:0] exp_rgb;

  task automatic modelReset();
    cur_line.delete();
    shown_line.delete();
    pend_q.delete();
    line_len_m  = 512;
    k_out       = 0;
    last_ice    = -1000;
    shown_valid = 0;
    synced_m    = 0;
    prev_hs     = 1;
    lat_vblk    = 1;
    lat_vsyn    = 1;
    ov_vblk     = 1;
    ov_vsyn     = 1;
  endtask

  initial begin
    cyc = 0;
    started = 0;
    modelReset();
    forever begin
      @(posedge MCLK);
      #1;
      cyc++;
      if (RESET) begin
        started = 1;
        checkOutput("rst_oce", oCE, 0);
        checkOutput("rst_rgb", oRGB, 0);
        checkOutput("rst_hblk", oHBLK, 1);
        checkOutput("rst_vblk", oVBLK, 1);
        checkOutput("rst_hsyn", oHSYN, 1);
        checkOutput("rst_vsyn", oVSYN, 1);
        modelReset();
      end else if (started) begin
        if (iCE) begin
          last_ice = cyc;
          if (prev_hs && !iHSYN) begin
            shown_line  = cur_line;
            line_len_m  = (cur_line.size() < 511) ? cur_line.size() : 511;
            shown_valid = synced_m;
            synced_m    = 1;
            ov_vblk     = lat_vblk;
            ov_vsyn     = lat_vsyn;
            lat_vblk    = iVBLK;
            lat_vsyn    = iVSYN;
            k_out       = 0;
            cur_line.delete();
          end
          prev_hs = iHSYN;
          cur_line.push_back({iHBLK, iRGB});
        end
        exp_oce = (cyc == last_ice) || (cyc == last_ice + CE_HALF);
        checkOutput("oce", oCE, exp_oce);
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          p = pend_q.pop_front();
          blank = !p.valid || p.px[12];
          if (blank)              exp_rgb = 12'h000;
          else if (p.rep && iSL)  exp_rgb = (p.px[11:0] >> 1) & 12'h777;
          else                    exp_rgb = p.px[11:0];
          checkOutput("rgb", oRGB, exp_rgb);
          checkOutput("hblk", oHBLK, blank);
          checkOutput("hsyn", oHSYN, p.hsyn);
          checkOutput("vblk", oVBLK, ov_vblk);
          checkOutput("vsyn", oVSYN, ov_vsyn);
        end
        if (exp_oce) begin
          eff     = (line_len_m == 0) ? 512 : line_len_m;
          idx     = k_out % eff;
          p.due   = cyc + 2;
          p.valid = shown_valid && (idx < shown_line.size());
          p.px    = p.valid ? shown_line[idx] : 13'h1000;
          p.rep   = ((k_out / eff) % 2) == 1;
          p.hsyn  = idx >= HSW;
          pend_q.push_back(p);
          k_out++;
        end
      end
    end
  end

  // Drives one input line; iCE every 2*CE_HALF cycles, optional one-cycle reset after pixel rst_at.
  task automatic applyStimulus(input int npix, input int hs_start, input int hs_len,
                               input int active, input int pmode, input bit vblk,
                               input bit vsyn, input bit sl, input int rst_at);
    for (int n = 0; n < npix; n++) begin
      @(negedge MCLK);
      iCE   = 1'b1;
      iSL   = sl;
      iVBLK = vblk;
      iVSYN = vsyn;
      iHBLK = (n >= active);
      iHSYN = !(n >= hs_start && n < hs_start + hs_len);
      case (pmode)
        0:       iRGB = 12'($urandom);
        1:       iRGB = 12'(n);
        default: iRGB = 12'hFFF;
      endcase
      @(negedge MCLK);
      iCE = 1'b0;
      if (n == rst_at) RESET = 1'b1;
      repeat (2 * CE_HALF - 2) begin
        @(negedge MCLK);
        RESET = 1'b0;
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    iCE   = 1'($urandom);
    iRGB  = 12'($urandom);
    iHSYN = 1'($urandom);
    repeat (2) begin
      @(negedge MCLK);
      iCE   = 1'($urandom);
      iRGB  = 12'($urandom);
      iHBLK = 1'($urandom);
      iHSYN = 1'($urandom);
      iVBLK = 1'($urandom);
      iVSYN = 1'($urandom);
      iSL   = 1'($urandom);
    end
    @(negedge MCLK);
    RESET = 1'b0;
    iCE   = 1'b0;
    iHSYN = 1'b1;
    iVSYN = 1'b1;
    iSL   = 1'b0;

    $display("[TB] basic doubling, ramp lines");
    repeat (4) applyStimulus(384, 256, 56, 256, 1, 1'b0, 1'b1, 1'b0, -1);

    $display("[TB] scanline dimming");
    repeat (3) applyStimulus(64, 0, 8, 64, 2, 1'b0, 1'b1, 1'b1, -1);
    repeat (2) applyStimulus(64, 0, 8, 64, 2, 1'b0, 1'b1, 1'b0, -1);

    $display("[TB] vertical alignment");
    for (int l = 0; l < 14; l++)
      applyStimulus(48, 0, 8, 40, 0, l >= 6, !(l >= 8 && l < 11), 1'($urandom), -1);

    $display("[TB] overflow and length change");
    applyStimulus(600, 0, 8, $urandom_range(200, 600), 0, 1'b0, 1'b1, 1'($urandom), -1);
    applyStimulus(300, 0, 8, $urandom_range(100, 300), 0, 1'b0, 1'b1, 1'($urandom), -1);
    applyStimulus(300, 0, 8, $urandom_range(100, 300), 0, 1'b0, 1'b1, 1'($urandom), -1);

    $display("[TB] mid-line reset");
    applyStimulus(384, 0, 8, 320, 0, 1'b0, 1'b1, 1'b0, 100);
    repeat (3) applyStimulus(384, 0, 8, $urandom_range(40, 384), 0, 1'b0, 1'b1, 1'($urandom), -1);

    repeat (4) @(negedge MCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
